// File: rtl/adder_share_sched_if.sv
// Request/response bundle between lab-board requesters and the shared bit-serial adder.
// master = requesters plus result consumer; slave = the scheduler.
interface adder_share_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/adder_share_sched.sv
// Round-robin scheduler sharing one 1-bit full adder among NREQ requesters;
// each add runs LSB first, one bit per clock, and returns {cout, sum} with the owner id.
module adder_share_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  adder_share_sched_if.slave  bus,
  output logic                busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int XW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_reg;
  logic [IDW-1:0]   ptr_reg;
  logic [IDW-1:0]   id_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [XW-1:0]    idx_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             rsp_valid_reg;
  logic             busy_reg;

  // rot_idx[k] is the requester examined k-th when searching from ptr.
  logic [IDW-1:0]  rot_idx [NREQ];
  logic [NREQ-1:0] rot_req;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [IDW:0] raw;
      assign raw          = {1'b0, ptr_reg} + (IDW+1)'(gi);
      assign rot_idx[gi]  = (raw >= (IDW+1)'(NREQ)) ? IDW'(raw - (IDW+1)'(NREQ)) : raw[IDW-1:0];
      assign rot_req[gi]  = bus.req_valid[rot_idx[gi]];
    end
  endgenerate

  logic [IDW-1:0]  gidx;
  logic [NREQ-1:0] grant;
  logic            accept;

  always_comb begin
    gidx = rot_idx[0];
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_req[k]) gidx = rot_idx[k];
    end
    accept = (state_reg == IDLE) && (|rot_req);
    grant  = '0;
    if (accept) grant[gidx] = 1'b1;
  end

  logic           bit_sum;
  logic           bit_carry;
  logic [IDW-1:0] ptr_next;

  assign bit_sum   = a_reg[idx_reg] ^ b_reg[idx_reg] ^ carry_reg;
  assign bit_carry = (a_reg[idx_reg] & b_reg[idx_reg]) | (carry_reg & (a_reg[idx_reg] ^ b_reg[idx_reg]));
  // The just-served requester drops to lowest priority.
  assign ptr_next  = (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      id_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= bus.req_a[gidx*WIDTH +: WIDTH];
            b_reg     <= bus.req_b[gidx*WIDTH +: WIDTH];
            carry_reg <= bus.req_cin[gidx];
            id_reg    <= gidx;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ADD;
          end
        end
        ADD: begin
          sum_reg[idx_reg] <= bit_sum;
          carry_reg        <= bit_carry;
          if (idx_reg == XW'(WIDTH - 1)) begin
            cout_reg      <= bit_carry;
            rsp_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            ptr_reg       <= ptr_next;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = id_reg;
  assign bus.rsp_sum   = sum_reg;
  assign bus.rsp_cout  = cout_reg;
  assign busy          = busy_reg;
endmodule

// File: tb/tb_adder_share_sched.sv
// Bench for adder_share_sched: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_adder_share_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  adder_share_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  adder_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: one outstanding add, result known at grant time.
  bit               m_busy = 0;
  bit               m_pend = 0;
  int               m_left = 0;
  int               m_ptr  = 0;
  int               m_id   = 0;
  logic [WIDTH-1:0] m_sum  = '0;
  logic             m_cout = 1'b0;
  int               gq[$];
  int               gcyc[$];
  bit               granted[NREQ];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int pick(input int p, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [NREQ-1:0]  exp_ready;
    logic [WIDTH:0]   total;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    int               g;
    cyc++;
    exp_ready = '0;
    g = -1;
    if (!rst) begin
      if (!m_busy && (|bus.req_valid)) begin
        g = pick(m_ptr, bus.req_valid);
        exp_ready[g] = 1'b1;
      end
      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_pend));
      chk("busy", 64'(busy), 64'(m_busy));
      if (m_pend) begin
        chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
        chk("rsp_sum", 64'(bus.rsp_sum), 64'(m_sum));
        chk("rsp_cout", 64'(bus.rsp_cout), 64'(m_cout));
      end
    end
    if (rst) begin
      m_busy = 0; m_pend = 0; m_left = 0; m_ptr = 0;
    end else if (m_pend) begin
      if (bus.rsp_ready) begin
        m_pend = 0; m_busy = 0; m_ptr = (m_id + 1) % NREQ;
      end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) m_pend = 1;
    end else if (g >= 0) begin
      opa    = bus.req_a[g*WIDTH +: WIDTH];
      opb    = bus.req_b[g*WIDTH +: WIDTH];
      total  = {1'b0, opa} + {1'b0, opb} + (WIDTH+1)'(bus.req_cin[g]);
      m_sum  = total[WIDTH-1:0];
      m_cout = total[WIDTH];
      m_id   = g;
      m_busy = 1;
      m_left = WIDTH;
      gq.push_back(g);
      gcyc.push_back(cyc);
      granted[g] = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
    bus.req_cin[i]   = cin;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) return;
    end
    chk("grant_timeout", 64'(bus.req_ready[i]), 64'd1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid) return;
    end
    chk("rsp_timeout", 64'(bus.rsp_valid), 64'd1);
  endtask

  task automatic run_add(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input bit scramble, output int lat,
                         output int id, output logic [WIDTH-1:0] sum, output logic cout);
    set_req(i, a, b, cin);
    wait_grant(i);
    tick();
    bus.req_valid[i] = 1'b0;
    if (scramble) begin
      bus.req_a[i*WIDTH +: WIDTH] = ~a;
      bus.req_b[i*WIDTH +: WIDTH] = a ^ 8'h5A;
      bus.req_cin[i] = ~cin;
    end
    wait_rsp(lat);
    id   = int'(bus.rsp_id);
    sum  = bus.rsp_sum;
    cout = bus.rsp_cout;
    tick();
  endtask

  initial begin
    int               lat;
    int               id;
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               exp3[5] = '{0, 1, 2, 3, 0};
    int               exp4[3] = '{1, 2, 1};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;

    do_reset();
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("reset_rsp_sum", 64'(bus.rsp_sum), 64'd0);
    chk("reset_rsp_cout", 64'(bus.rsp_cout), 64'd0);

    // Basic add, latency and result
    bus.rsp_ready = 1'b1;
    run_add(0, 8'h35, 8'h4A, 1'b0, 0, lat, id, sum, cout);
    $display("txn add0: id=%0d sum=%02h cout=%0d latency=%0d", id, sum, cout, lat);
    chk("t1_latency", 64'(lat), 64'd9);
    chk("t1_id", 64'(id), 64'd0);
    chk("t1_sum", 64'(sum), 64'h7F);
    chk("t1_cout", 64'(cout), 64'd0);

    // Carry propagation and wrap
    run_add(2, 8'hFF, 8'h01, 1'b1, 0, lat, id, sum, cout);
    $display("txn add2: id=%0d sum=%02h cout=%0d", id, sum, cout);
    chk("t2a_id", 64'(id), 64'd2);
    chk("t2a_sum", 64'(sum), 64'h01);
    chk("t2a_cout", 64'(cout), 64'd1);
    run_add(2, 8'h80, 8'h80, 1'b0, 0, lat, id, sum, cout);
    $display("txn add2: id=%0d sum=%02h cout=%0d", id, sum, cout);
    chk("t2b_sum", 64'(sum), 64'h00);
    chk("t2b_cout", 64'(cout), 64'd1);

    // Operands change after accept
    run_add(3, 8'h10, 8'h20, 1'b0, 1, lat, id, sum, cout);
    $display("txn add3 scrambled: id=%0d sum=%02h cout=%0d", id, sum, cout);
    chk("t6_id", 64'(id), 64'd3);
    chk("t6_sum", 64'(sum), 64'h30);
    chk("t6_cout", 64'(cout), 64'd0);

    // All requesting, rsp_ready held: rotation and spacing
    do_reset();
    gq.delete();
    gcyc.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    repeat (55) tick();
    bus.req_valid = '0;
    chk("t3_grant_count_ok", 64'(gq.size() >= 5), 64'd1);
    if (gq.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        $display("txn rr grant %0d: id=%0d cycle=%0d", k, gq[k], gcyc[k]);
        chk("t3_grant_id", 64'(gq[k]), 64'(exp3[k]));
        if (k > 0) chk("t3_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'd10);
      end
    end

    // Backpressure in DONE, then rotation 1 -> 2 -> 1
    do_reset();
    gq.delete();
    gcyc.delete();
    bus.rsp_ready = 1'b0;
    set_req(1, 8'h11, 8'h22, 1'b1);
    wait_grant(1);
    tick();
    set_req(2, 8'h0F, 8'hF0, 1'b0);
    wait_rsp(lat);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("t4_hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t4_hold_ready", 64'(bus.req_ready), 64'd0);
      chk("t4_hold_id", 64'(bus.rsp_id), 64'd1);
      chk("t4_hold_sum", 64'(bus.rsp_sum), 64'h34);
    end
    tick();
    bus.rsp_ready = 1'b1;
    repeat (30) tick();
    bus.req_valid = '0;
    chk("t4_grant_count_ok", 64'(gq.size() >= 3), 64'd1);
    if (gq.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        $display("txn bp grant %0d: id=%0d", k, gq[k]);
        chk("t4_grant_id", 64'(gq[k]), 64'(exp4[k]));
      end
    end

    // Reset in the middle of ADD
    do_reset();
    set_req(1, 8'hAA, 8'h55, 1'b0);
    wait_grant(1);
    tick();
    bus.req_valid[1] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("txn mid-add reset: busy=%0d rsp_valid=%0d", busy, bus.rsp_valid);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    set_req(0, 8'h01, 8'h02, 1'b0);
    set_req(3, 8'h03, 8'h04, 1'b0);
    wait_grant(0);
    chk("t5_grant0", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = '0;
    repeat (12) tick();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < NREQ; i++) granted[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (granted[i]) begin
          granted[i] = 0;
          bus.req_valid[i] = 1'b0;
        end else if (!bus.req_valid[i]) begin
          if ($urandom_range(3) == 0) set_req(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
          else begin
            bus.req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            bus.req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          end
        end else if ($urandom_range(63) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(2) != 0);
      rst = ($urandom_range(399) == 0);
    end
    rst = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (20) tick();
    $display("txn random phase done: %0d grants", gq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
